sent_tx_crc_gen: RTL and testbench

Transmit-side SENT (SAE J2716) CRC generator.
- Takes a frame payload from the TX frame formatter and computes the CRC for one of three frame types: fast-channel nibbles, short serial message, or enhanced serial message.
- Uses the recommended augmented-CRC method, processing one chunk per clock.
- Returns the CRC with a one-cycle valid pulse. The formatter then appends it as the CRC nibble or places it in the enhanced serial CRC bits.

---
 rtl/sent_crc_pkg.sv | 58 +++++
 rtl/sent_crc_lfsr.sv | 52 +++++
 rtl/sent_tx_crc_gen.sv | 164 ++++++++++++++++
 tb/tb_sent_tx_crc_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sent_crc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sent_crc_pkg
// Description : Shared SENT (SAE J2716) CRC definitions for the TX generator
//               and the RX checker: frame-type codes, default seeds,
//               generator polynomials, FSM state type and single-chunk
//               CRC step functions.
// Revision    : 1.0 - initial release
// ============================================================================
package sent_crc_pkg;

    // Frame-type codes carried on mode_i (2'b11 is reserved / illegal)
    localparam logic [1:0] MODE_FAST  = 2'b00;
    localparam logic [1:0] MODE_SHORT = 2'b01;
    localparam logic [1:0] MODE_ENH   = 2'b10;

    // Default seeds
    localparam logic [3:0] SEED4_DEFAULT = 4'b0101;
    localparam logic [5:0] SEED6_DEFAULT = 6'b010101;

    // Generator polynomials with the implicit leading term dropped:
    //   x^4 + x^3 + x^2 + 1        -> 4'b1101
    //   x^6 + x^4 + x^3 + 1        -> 6'b011001
    localparam logic [3:0] POLY4 = 4'b1101;
    localparam logic [5:0] POLY6 = 6'b011001;

    // Generator FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_AUG  = 2'd2
    } tx_state_t;

    // One augmented step: multiply the running CRC by x^4 modulo the
    // polynomial (four single-bit shifts), then fold in the new nibble.
    function automatic logic [3:0] crc4_step(input logic [3:0] crc,
                                             input logic [3:0] nib);
        logic [3:0] v;
        v = crc;
        for (int i = 0; i < 4; i++) begin
            v = v[3] ? ({v[2:0], 1'b0} ^ POLY4) : {v[2:0], 1'b0};
        end
        return v ^ nib;
    endfunction

    // Same as crc4_step for the 6-bit enhanced-serial CRC.
    function automatic logic [5:0] crc6_step(input logic [5:0] crc,
                                             input logic [5:0] chunk);
        logic [5:0] v;
        v = crc;
        for (int i = 0; i < 6; i++) begin
            v = v[5] ? ({v[4:0], 1'b0} ^ POLY6) : {v[4:0], 1'b0};
        end
        return v ^ chunk;
    endfunction

endpackage : sent_crc_pkg
`default_nettype wire

// File: rtl/sent_crc_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : sent_crc_lfsr
// Description : 6-bit SENT CRC register with seed load and one-chunk step.
//               wide_i selects the 6-bit CRC; otherwise the 4-bit CRC lives
//               in [3:0] with [5:4] held at zero.
// Ports       : clk_i        clock
//               rst_i        asynchronous active-high reset (loads 4-bit seed)
//               load_seed_i  load seed selected by wide_i
//               step_i       advance the register by one chunk
//               wide_i       1 = 6-bit CRC, 0 = 4-bit CRC
//               chunk_i      chunk to fold in (nibble in [3:0] when narrow)
//               step_crc_o   value the register takes on a step this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module sent_crc_lfsr
    import sent_crc_pkg::*;
#(
    parameter logic [3:0] SEED4 = SEED4_DEFAULT,
    parameter logic [5:0] SEED6 = SEED6_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_seed_i,
    input  logic       step_i,
    input  logic       wide_i,
    input  logic [5:0] chunk_i,
    output logic [5:0] step_crc_o
);

    logic [5:0] crc_q;
    logic [5:0] crc_d;

    always_comb begin
        crc_d = wide_i ? crc6_step(crc_q, chunk_i)
                       : {2'b00, crc4_step(crc_q[3:0], chunk_i[3:0])};
    end

    assign step_crc_o = crc_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q <= {2'b00, SEED4};
        end else if (load_seed_i) begin
            crc_q <= wide_i ? SEED6 : {2'b00, SEED4};
        end else if (step_i) begin
            crc_q <= crc_d;
        end
    end

endmodule : sent_crc_lfsr
`default_nettype wire

// File: rtl/sent_tx_crc_gen.sv
`default_nettype none
// ============================================================================
// Module      : sent_tx_crc_gen
// Description : Transmit-side SENT CRC generator. Computes the augmented CRC
//               of a fast-channel, short-serial or enhanced-serial payload,
//               one chunk per clock, and returns it with a valid pulse.
// Ports       : clk_tx        TX clock
//               reset_tx      asynchronous active-high reset
//               start_i       request, sampled only while idle
//               mode_i        frame type (00 fast, 01 short, 10 enhanced)
//               nibble_cnt_i  fast-channel nibble count (3, 4 or 6)
//               data_i        left-aligned MSB-first payload
//               busy_o        calculation in progress
//               crc_o         last result (4-bit CRCs in [3:0])
//               crc_valid_o   one-cycle pulse, crc_o updated
//               err_o         one-cycle pulse, request rejected
// Revision    : 1.0 - initial release
// ============================================================================
module sent_tx_crc_gen
    import sent_crc_pkg::*;
#(
    parameter logic [3:0] SEED4 = SEED4_DEFAULT,
    parameter logic [5:0] SEED6 = SEED6_DEFAULT
) (
    input  logic        clk_tx,
    input  logic        reset_tx,
    input  logic        start_i,
    input  logic [1:0]  mode_i,
    input  logic [2:0]  nibble_cnt_i,
    input  logic [23:0] data_i,
    output logic        busy_o,
    output logic [5:0]  crc_o,
    output logic        crc_valid_o,
    output logic        err_o
);

    tx_state_t   state_q, state_d;
    logic [1:0]  mode_q;
    logic [2:0]  k_q;
    logic [2:0]  cnt_q;
    logic [23:0] data_q;
    logic [5:0]  crc_q;
    logic        crc_valid_q;
    logic        err_q;

    logic        w_legal;
    logic [2:0]  w_k_req;
    logic        w_accept;
    logic        w_reject;
    logic        w_step;
    logic        w_aug;
    logic        w_wide;
    logic [5:0]  w_chunk;
    logic [5:0]  w_step_crc;

    // Request decode
    always_comb begin
        w_k_req = 3'd4;
        if (mode_i == MODE_FAST) begin
            w_k_req = nibble_cnt_i;
        end else if (mode_i == MODE_SHORT) begin
            w_k_req = 3'd3;
        end
        w_legal = (mode_i != 2'b11) &&
                  ((mode_i != MODE_FAST) ||
                   (nibble_cnt_i == 3'd3) || (nibble_cnt_i == 3'd4) ||
                   (nibble_cnt_i == 3'd6));
    end

    // FSM next-state and control
    always_comb begin
        state_d  = state_q;
        w_accept = 1'b0;
        w_reject = 1'b0;
        w_step   = 1'b0;
        w_aug    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (w_legal) begin
                        w_accept = 1'b1;
                        state_d  = ST_CALC;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                w_step = 1'b1;
                if (cnt_q == (k_q - 3'd1)) begin
                    state_d = ST_AUG;
                end
            end
            ST_AUG: begin
                w_aug   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The seed width must follow the incoming mode on the load cycle and the
    // latched mode afterwards. The payload register is shifted left each step
    // so the next chunk is always at the top.
    always_comb begin
        w_wide  = w_accept ? (mode_i == MODE_ENH) : (mode_q == MODE_ENH);
        w_chunk = 6'd0;
        if (!w_aug) begin
            w_chunk = (mode_q == MODE_ENH) ? data_q[23:18]
                                           : {2'b00, data_q[23:20]};
        end
    end

    sent_crc_lfsr #(
        .SEED4 (SEED4),
        .SEED6 (SEED6)
    ) u_lfsr (
        .clk_i       (clk_tx),
        .rst_i       (reset_tx),
        .load_seed_i (w_accept),
        .step_i      (w_step | w_aug),
        .wide_i      (w_wide),
        .chunk_i     (w_chunk),
        .step_crc_o  (w_step_crc)
    );

    always_ff @(posedge clk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_FAST;
            k_q         <= 3'd0;
            cnt_q       <= 3'd0;
            data_q      <= 24'd0;
            crc_q       <= 6'd0;
            crc_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_valid_q <= w_aug;
            err_q       <= w_reject;
            if (w_accept) begin
                mode_q <= mode_i;
                k_q    <= w_k_req;
                data_q <= data_i;
                cnt_q  <= 3'd0;
            end else if (w_step) begin
                cnt_q  <= cnt_q + 3'd1;
                data_q <= (mode_q == MODE_ENH) ? (data_q << 6) : (data_q << 4);
            end
            if (w_aug) begin
                crc_q <= w_step_crc;
            end
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign crc_o       = crc_q;
    assign crc_valid_o = crc_valid_q;
    assign err_o       = err_q;

endmodule : sent_tx_crc_gen
`default_nettype wire

// File: tb/tb_sent_tx_crc_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sent_tx_crc_gen
// Description : Self-checking bench for sent_tx_crc_gen. A driver issues
//               directed and random requests and queues the expected result
//               (value and arrival cycle); a monitor pops and compares on
//               every crc_valid_o / err_o pulse. Expected CRCs come from a
//               polynomial long-division model of the augmented message.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sent_tx_crc_gen;

    localparam logic [3:0] TB_SEED4 = 4'b0101;
    localparam logic [5:0] TB_SEED6 = 6'b010101;

    logic        clk_tx = 1'b0;
    logic        reset_tx;
    logic        start_i;
    logic [1:0]  mode_i;
    logic [2:0]  nibble_cnt_i;
    logic [23:0] data_i;
    logic        busy_o;
    logic [5:0]  crc_o;
    logic        crc_valid_o;
    logic        err_o;

    typedef struct {
        bit         is_err;
        logic [5:0] crc;
        int         due;
    } exp_t;

    exp_t       sb[$];
    int         vectors = 0;
    int         errs    = 0;
    int         cyc     = 0;
    logic [5:0] last_crc = 6'd0;

    sent_tx_crc_gen dut (
        .clk_tx       (clk_tx),
        .reset_tx     (reset_tx),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .nibble_cnt_i (nibble_cnt_i),
        .data_i       (data_i),
        .busy_o       (busy_o),
        .crc_o        (crc_o),
        .crc_valid_o  (crc_valid_o),
        .err_o        (err_o)
    );

    always #5 clk_tx = ~clk_tx;
    always @(posedge clk_tx) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: the augmented CRC is the remainder of
    // (seed, chunk_0 .. chunk_{K-1}, zero chunk) read as one polynomial.
    function automatic logic [5:0] ref_crc(input logic [1:0] m, input int k,
                                           input logic [23:0] d);
        int          w;
        logic [63:0] msg;
        logic [63:0] poly;
        logic [63:0] mask;
        w    = (m == 2'b10) ? 6 : 4;
        msg  = (w == 6) ? 64'(TB_SEED6) : 64'(TB_SEED4);
        poly = (w == 6) ? 64'h59 : 64'h1D;
        mask = (64'd1 << w) - 64'd1;
        for (int i = 0; i < k; i++) begin
            msg = (msg << w) | ((64'(d) >> (24 - w * (i + 1))) & mask);
        end
        msg = msg << w;
        for (int b = 63; b >= w; b--) begin
            if (msg[b]) msg = msg ^ (poly << (b - w));
        end
        return 6'(msg & mask);
    endfunction

    function automatic int steps_for(input logic [1:0] m, input logic [2:0] n);
        if (m == 2'b00) return int'(n);
        if (m == 2'b01) return 3;
        return 4;
    endfunction

    function automatic bit is_legal(input logic [1:0] m, input logic [2:0] n);
        if (m == 2'b11) return 1'b0;
        if (m == 2'b00) return (n == 3'd3) || (n == 3'd4) || (n == 3'd6);
        return 1'b1;
    endfunction

    // Wait for idle, present a request, queue its expectation.
    task automatic issue(input logic [1:0] m, input logic [2:0] n,
                         input logic [23:0] d, input logic [5:0] exp_crc,
                         input bit hold);
        int   w;
        exp_t e;
        bit   legal;
        @(negedge clk_tx);
        w = 0;
        while (busy_o && w < 64) begin
            @(negedge clk_tx);
            w++;
        end
        if (busy_o) chk("busy_timeout", 32'(busy_o), 32'd0);
        legal        = is_legal(m, n);
        mode_i       = m;
        nibble_cnt_i = n;
        data_i       = d;
        start_i      = 1'b1;
        e.is_err     = !legal;
        e.crc        = exp_crc;
        e.due        = legal ? cyc + steps_for(m, n) + 2 : cyc + 1;
        sb.push_back(e);
        if (!hold) begin
            @(negedge clk_tx);
            start_i = 1'b0;
            chk("busy_after_request", 32'(busy_o), 32'(legal));
            // Inputs changing mid-calculation must not matter
            data_i       = $urandom;
            mode_i       = 2'($urandom_range(0, 3));
            nibble_cnt_i = 3'($urandom_range(0, 7));
        end
    endtask

    // Monitor
    always @(negedge clk_tx) begin
        if (!reset_tx) begin
            if (sb.size() > 0 && cyc > sb[0].due) begin
                chk("output_missing", 32'd0, 32'd1);
                void'(sb.pop_front());
            end
            if (crc_valid_o || err_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", {30'd0, crc_valid_o, err_o}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("err_flag", 32'(err_o), 32'(e.is_err));
                    chk("valid_flag", 32'(crc_valid_o), 32'(!e.is_err));
                    chk("latency", 32'(cyc), 32'(e.due));
                    chk("busy_at_output", 32'(busy_o), 32'd0);
                    if (e.is_err) begin
                        chk("crc_hold_on_err", 32'(crc_o), 32'(last_crc));
                    end else begin
                        chk("crc_value", 32'(crc_o), 32'(e.crc));
                        last_crc = e.crc;
                    end
                end
            end
        end
    end

    initial begin
        int         n;
        logic [1:0] m;
        logic [2:0] nc;
        logic [23:0] d;

        reset_tx     = 1'b1;
        start_i      = 1'b0;
        mode_i       = 2'b00;
        nibble_cnt_i = 3'd3;
        data_i       = 24'd0;
        repeat (2) @(negedge clk_tx);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_crc", 32'(crc_o), 32'd0);
        chk("reset_valid", 32'(crc_valid_o), 32'd0);
        chk("reset_err", 32'(err_o), 32'd0);
        @(posedge clk_tx);
        #2 reset_tx = 1'b0;

        // Known-answer requests
        issue(2'b00, 3'd3, 24'h000000, 6'h09, 1'b0);
        issue(2'b00, 3'd4, 24'h000000, 6'h0C, 1'b0);
        issue(2'b00, 3'd6, 24'h000000, 6'h05, 1'b0);
        issue(2'b10, 3'd0, 24'h000000, 6'h26, 1'b0);
        issue(2'b01, 3'd7, 24'h000FFF, 6'h09, 1'b0);

        // Rejected requests
        issue(2'b00, 3'd5, 24'h123456, 6'h00, 1'b0);
        issue(2'b11, 3'd3, 24'h000000, 6'h00, 1'b0);

        // start_i held high: back-to-back results every K+2 cycles
        issue(2'b00, 3'd3, 24'h000000, 6'h09, 1'b1);
        issue(2'b00, 3'd3, 24'h000000, 6'h09, 1'b1);
        issue(2'b00, 3'd3, 24'h000000, 6'h09, 1'b1);
        issue(2'b00, 3'd3, 24'h000000, 6'h09, 1'b0);

        // Reset during the second data step
        issue(2'b00, 3'd3, 24'hABCDEF, ref_crc(2'b00, 3, 24'hABCDEF), 1'b0);
        @(posedge clk_tx);
        #2 reset_tx = 1'b1;
        sb.delete();
        last_crc = 6'd0;
        #1;
        chk("midreset_busy", 32'(busy_o), 32'd0);
        chk("midreset_crc", 32'(crc_o), 32'd0);
        chk("midreset_valid", 32'(crc_valid_o), 32'd0);
        chk("midreset_err", 32'(err_o), 32'd0);
        @(posedge clk_tx);
        #2 reset_tx = 1'b0;
        issue(2'b00, 3'd3, 24'h000000, 6'h09, 1'b0);

        // Random requests against the reference model
        for (int i = 0; i < 60; i++) begin
            m = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       nc = 3'd3;
                1:       nc = 3'd4;
                2:       nc = 3'd6;
                default: nc = 3'($urandom_range(0, 7));
            endcase
            d = 24'($urandom);
            issue(m, nc, d, ref_crc(m, steps_for(m, nc), d), 1'b0);
        end

        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk_tx);
            n++;
        end
        if (sb.size() > 0) chk("drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule : tb_sent_tx_crc_gen
`default_nettype wire
